// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the 80x60 framebuffer MMIO controller.
// The optional completion interrupt is enabled with VGA_FB_DONE_IRQ_EN.
package vga_fb_pkg;

  localparam logic [31:0] BASE_AD    = 32'h1100_0120;
  localparam logic [31:0] OFF_ADDR   = 32'h00;
  localparam logic [31:0] OFF_COLOR  = 32'h20;
  localparam logic [31:0] OFF_READ   = 32'h40;
  localparam logic [31:0] OFF_RECT   = 32'h60;
  localparam logic [31:0] OFF_STATUS = 32'h80;

  localparam int unsigned FB_COLS = 80;
  localparam int unsigned FB_ROWS = 60;

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  typedef struct packed {
    logic [6:0] col;
    logic [5:0] row;
  } fb_coord_t;

  // Framebuffer addresses are {row, col}; the struct orders fields col-first.
  function automatic fb_coord_t addr_to_coord(input logic [12:0] addr);
    fb_coord_t c;
    c.col = addr[6:0];
    c.row = addr[12:7];
    return c;
  endfunction

endpackage

// File: rtl/vga_fb_ctrl_rect_fill_engine.sv
// Rectangle-fill engine: walks a W x H block one pixel per cycle, clipping
// pixels outside the visible area and holding its counters while stalled.
module rect_fill_engine #(
  parameter int unsigned FB_COLS = vga_fb_pkg::FB_COLS,
  parameter int unsigned FB_ROWS = vga_fb_pkg::FB_ROWS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic [12:0] origin,
  input  logic [7:0]  color,
  input  logic [6:0]  width,
  input  logic [5:0]  height,
  output logic        busy,
  output logic        done,
  output logic        pix_valid,
  output logic        pix_we,
  output logic [12:0] pix_addr,
  output logic [7:0]  pix_color
);
  import vga_fb_pkg::*;

  localparam logic [7:0] COL_LIM = 8'(FB_COLS);
  localparam logic [7:0] ROW_LIM = 8'(FB_ROWS);

  fill_state_t state, state_next;
  fb_coord_t   org;
  logic [7:0]  color_q;
  logic [6:0]  w_q, c_q;
  logic [5:0]  h_q, r_q;
  logic [7:0]  col8, row8;
  logic        last_col, last_pix;

  assign last_col = (c_q == w_q - 7'd1);
  assign last_pix = last_col && (r_q == h_q - 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      org     <= '0;
      color_q <= '0;
      w_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        org     <= addr_to_coord(origin);
        color_q <= color;
        w_q     <= width;
        h_q     <= height;
        c_q     <= '0;
        r_q     <= '0;
      end else if (state == FILL && !stall) begin
        if (last_col) begin
          c_q <= '0;
          r_q <= r_q + 6'd1;
        end else begin
          c_q <= c_q + 7'd1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (width == '0 || height == '0) ? DONE : FILL;
      FILL: if (!stall && last_pix) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // 8-bit sums so that overflow past column 127 / row 63 clips instead of wrapping.
  assign col8      = {1'b0, org.col} + {1'b0, c_q};
  assign row8      = {2'b0, org.row} + {2'b0, r_q};
  assign pix_valid = (state == FILL) && !stall;
  assign pix_we    = pix_valid && (col8 < COL_LIM) && (row8 < ROW_LIM);
  assign pix_addr  = {row8[5:0], col8[6:0]};
  assign pix_color = color_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: rtl/vga_fb_ctrl.sv
// MMIO front end sharing the framebuffer write/read port between CPU pixel
// writes and the rectangle-fill engine. DONE_IRQ is live only with VGA_FB_DONE_IRQ_EN.
module vga_fb_ctrl #(
  parameter int unsigned FB_COLS = vga_fb_pkg::FB_COLS,
  parameter int unsigned FB_ROWS = vga_fb_pkg::FB_ROWS,
  parameter logic [31:0] BASE_AD = vga_fb_pkg::BASE_AD
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic [12:0] FB_WA,
  output logic [7:0]  FB_WD,
  output logic        FB_WE,
  input  logic [7:0]  FB_RD,
  output logic        BUSY,
  output logic        DONE_IRQ
);
  import vga_fb_pkg::*;

  logic [12:0] addr_q;
  logic [7:0]  color_q;
  logic        err_q;
  logic        wr_addr, wr_color, wr_rect, wr_status;
  logic        busy, done, pix_valid, pix_we;
  logic [12:0] pix_addr;
  logic [7:0]  pix_color;

  assign wr_addr   = IOBUS_WR && (IOBUS_ADDR == BASE_AD + OFF_ADDR);
  assign wr_color  = IOBUS_WR && (IOBUS_ADDR == BASE_AD + OFF_COLOR);
  assign wr_rect   = IOBUS_WR && (IOBUS_ADDR == BASE_AD + OFF_RECT);
  assign wr_status = IOBUS_WR && (IOBUS_ADDR == BASE_AD + OFF_STATUS);

  rect_fill_engine #(
    .FB_COLS (FB_COLS),
    .FB_ROWS (FB_ROWS)
  ) u_engine (
    .clk       (CLK),
    .rst_n     (RST_N),
    .start     (wr_rect),
    .stall     (wr_color),
    .origin    (addr_q),
    .color     (color_q),
    .width     (IOBUS_OUT[6:0]),
    .height    (IOBUS_OUT[13:8]),
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_we    (pix_we),
    .pix_addr  (pix_addr),
    .pix_color (pix_color)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q  <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
      FB_WA   <= '0;
      FB_WD   <= '0;
      FB_WE   <= 1'b0;
    end else begin
      if (wr_addr)  addr_q  <= IOBUS_OUT[12:0];
      if (wr_color) color_q <= IOBUS_OUT[7:0];
      if (wr_status) err_q <= 1'b0;
      if (wr_rect && busy) err_q <= 1'b1;
      // CPU pixel wins; otherwise the engine; otherwise park on ADDR for READ.
      if (wr_color) begin
        FB_WA <= addr_q;
        FB_WD <= IOBUS_OUT[7:0];
        FB_WE <= 1'b1;
      end else if (pix_valid) begin
        FB_WA <= pix_addr;
        FB_WD <= pix_color;
        FB_WE <= pix_we;
      end else begin
        FB_WA <= wr_addr ? IOBUS_OUT[12:0] : addr_q;
        FB_WE <= 1'b0;
      end
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == BASE_AD + OFF_READ)
      IOBUS_IN = busy ? '0 : {24'h0, FB_RD};
    else if (IOBUS_ADDR == BASE_AD + OFF_STATUS)
      IOBUS_IN = {30'h0, err_q, busy};
  end

  assign BUSY = busy;

`ifdef VGA_FB_DONE_IRQ_EN
  assign DONE_IRQ = done;
  logic unused_bits;
  assign unused_bits = ^IOBUS_OUT[31:14];
`else
  assign DONE_IRQ = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{IOBUS_OUT[31:14], done};
`endif

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Scoreboard bench for vga_fb_ctrl: a queue-based pixel-list model predicts
// framebuffer writes, register reads, BUSY and DONE_IRQ for random MMIO traffic.
module tb_vga_fb_ctrl;

  localparam logic [31:0] BASE = 32'h1100_0120;
`ifdef VGA_FB_DONE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef enum int {OP_IDLE, OP_ADDR, OP_COLOR, OP_RECT, OP_STAT_WR, OP_READ, OP_STAT_RD} op_t;
  typedef struct { int cyc; logic [12:0] wa; logic [7:0] wd; } wr_exp_t;
  typedef struct { int cyc; logic [31:0] val; } rd_exp_t;
  typedef struct { logic [12:0] wa; logic [7:0] wd; bit vis; } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] iobus_addr = '0, iobus_out = '0, iobus_in;
  logic        iobus_wr = 1'b0;
  logic [12:0] fb_wa;
  logic [7:0]  fb_wd, fb_rd;
  logic        fb_we, busy, done_irq;

  vga_fb_ctrl dut (
    .CLK(clk), .RST_N(rst_n), .IOBUS_ADDR(iobus_addr), .IOBUS_OUT(iobus_out),
    .IOBUS_WR(iobus_wr), .IOBUS_IN(iobus_in), .FB_WA(fb_wa), .FB_WD(fb_wd),
    .FB_WE(fb_we), .FB_RD(fb_rd), .BUSY(busy), .DONE_IRQ(done_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0, total = 0;
  bit run = 0, in_reset = 0;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  pix_t    pix_q[$];
  logic [7:0] ref_mem [0:8191];
  logic [7:0] fb_mem  [0:8191];

  logic [12:0] m_addr = '0;
  logic [7:0]  m_color = '0;
  bit          m_err = 0, m_active = 0;
  int          m_start = 0, m_end = -1;

  function automatic logic [7:0] init_pat(input logic [12:0] a);
    return a[7:0] ^ {a[12:8], 3'b101};
  endfunction

  function automatic bit m_busy(input int t);
    return m_active && t >= m_start && (m_end < 0 || t <= m_end);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Framebuffer stand-in: combinational read, write committed at the clock edge.
  assign fb_rd = fb_mem[fb_wa];
  initial begin
    logic        we_s;
    logic [12:0] wa_s;
    logic [7:0]  wd_s;
    for (int i = 0; i < 8192; i++) fb_mem[i] = init_pat(13'(i));
    forever begin
      @(negedge clk);
      we_s = fb_we; wa_s = fb_wa; wd_s = fb_wd;
      @(posedge clk);
      if (we_s) fb_mem[wa_s] = wd_s;
    end
  end

  // Monitor: pops expected writes/reads and checks BUSY/DONE_IRQ every cycle.
  initial begin
    wr_exp_t e;
    rd_exp_t r;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_pat(13'(i));
    forever begin
      @(negedge clk);
      if (run && !in_reset) begin
        if (fb_we || (wr_q.size() > 0 && wr_q[0].cyc <= cyc)) begin
          if (wr_q.size() == 0) begin
            check("wr_unexpected", {19'h0, fb_wa}, 32'hFFFF_FFFF);
          end else begin
            e = wr_q.pop_front();
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
            check("wr_pixel", {11'h0, fb_we, fb_wa, fb_wd}, {11'h0, 1'b1, e.wa, e.wd});
            ref_mem[e.wa] = e.wd;
          end
        end
        while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
          r = rd_q.pop_front();
          check("iobus_in", iobus_in, r.val);
        end
        check("busy", 32'(busy), 32'(m_busy(cyc)));
        check("done_irq", 32'(done_irq), 32'(IRQ_EN && m_active && cyc == m_end));
      end
    end
  end

  task automatic do_op(input op_t kind, input logic [31:0] data);
    int  t = cyc;
    bit  busy_now = m_busy(t);
    bit  stall = 0;
    int  w, h, ocol, orow, col, row;
    pix_t p;
    iobus_wr = 1'b0;
    iobus_out = data;
    iobus_addr = BASE + 32'h10;
    case (kind)
      OP_ADDR: begin
        iobus_addr = BASE; iobus_wr = 1'b1; m_addr = data[12:0];
      end
      OP_COLOR: begin
        iobus_addr = BASE + 32'h20; iobus_wr = 1'b1;
        wr_q.push_back('{t + 1, m_addr, data[7:0]});
        m_color = data[7:0];
        stall = 1;
      end
      OP_RECT: begin
        iobus_addr = BASE + 32'h60; iobus_wr = 1'b1;
        if (busy_now) m_err = 1;
        else begin
          w = int'(data[6:0]); h = int'(data[13:8]);
          ocol = int'(m_addr[6:0]); orow = int'(m_addr[12:7]);
          for (int rr = 0; rr < h; rr++)
            for (int cc = 0; cc < w; cc++) begin
              col = ocol + cc; row = orow + rr;
              p.vis = (col < 80) && (row < 60);
              p.wa = {row[5:0], col[6:0]};
              p.wd = m_color;
              pix_q.push_back(p);
            end
          m_active = 1;
          m_start = t + 1;
          m_end = (w == 0 || h == 0) ? t + 1 : -1;
        end
      end
      OP_STAT_WR: begin
        iobus_addr = BASE + 32'h80; iobus_wr = 1'b1; m_err = 0;
      end
      OP_READ: begin
        iobus_addr = BASE + 32'h40;
        rd_q.push_back('{t, busy_now ? 32'h0 : {24'h0, ref_mem[m_addr]}});
      end
      OP_STAT_RD: begin
        iobus_addr = BASE + 32'h80;
        rd_q.push_back('{t, {30'h0, m_err, busy_now}});
      end
      default: ;
    endcase
    if (!stall && m_active && t >= m_start && pix_q.size() > 0) begin
      p = pix_q.pop_front();
      if (p.vis) wr_q.push_back('{t + 1, p.wa, p.wd});
      if (pix_q.size() == 0) m_end = t + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    in_reset = 1;
    rst_n = 1'b0;
    iobus_wr = 1'b0;
    iobus_addr = BASE + 32'h40;
    #2;
    check({tag, "_fb_we"}, 32'(fb_we), 32'h0);
    check({tag, "_fb_wa"}, 32'(fb_wa), 32'h0);
    check({tag, "_fb_wd"}, 32'(fb_wd), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done_irq"}, 32'(done_irq), 32'h0);
    check({tag, "_read"}, iobus_in, {24'h0, ref_mem[0]});
    wr_q.delete(); rd_q.delete(); pix_q.delete();
    m_active = 0; m_end = -1; m_addr = '0; m_color = '0; m_err = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 0;
    run = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [6:0] col;
    logic [5:0] row;
    if ($urandom_range(0, 1) == 1) begin
      col = 7'($urandom_range(70, 85));
      row = 6'($urandom_range(52, 63));
    end else begin
      col = 7'($urandom_range(0, 127));
      row = 6'($urandom_range(0, 63));
    end
    return {19'h0, row, col};
  endfunction

  initial begin
    int sel;
    @(posedge clk);
    #1;
    do_reset("reset");

    do_op(OP_ADDR, 32'h0105);
    do_op(OP_COLOR, 32'hE0);
    repeat (3) do_op(OP_IDLE, 0);
    do_op(OP_READ, 0);

    do_op(OP_ADDR, {19'h0, 6'd2, 7'd3});
    do_op(OP_COLOR, 32'h5A);
    do_op(OP_RECT, (32'd2 << 8) | 32'd4);
    repeat (10) do_op(OP_IDLE, 0);
    do_op(OP_STAT_RD, 0);

    do_op(OP_ADDR, {19'h0, 6'd10, 7'd78});
    do_op(OP_RECT, (32'd1 << 8) | 32'd4);
    repeat (6) do_op(OP_IDLE, 0);
    do_op(OP_RECT, (32'd3 << 8) | 32'd0);
    repeat (3) do_op(OP_IDLE, 0);

    do_op(OP_ADDR, {19'h0, 6'd5, 7'd5});
    do_op(OP_COLOR, 32'h33);
    do_op(OP_RECT, (32'd3 << 8) | 32'd3);
    do_op(OP_IDLE, 0);
    do_op(OP_COLOR, 32'h77);
    do_op(OP_RECT, (32'd1 << 8) | 32'd1);
    do_op(OP_STAT_RD, 0);
    do_op(OP_READ, 0);
    repeat (12) do_op(OP_IDLE, 0);
    do_op(OP_STAT_RD, 0);
    do_op(OP_STAT_WR, 0);
    do_op(OP_STAT_RD, 0);
    do_op(OP_READ, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_op(OP_ADDR, {19'h0, 6'd20, 7'd20});
        do_op(OP_RECT, (32'd3 << 8) | 32'd5);
        do_op(OP_IDLE, 0);
        do_reset("mid_reset");
      end
      sel = $urandom_range(0, 99);
      if (sel < 15)      do_op(OP_ADDR, rand_addr());
      else if (sel < 30) do_op(OP_COLOR, $urandom());
      else if (sel < 42) do_op(OP_RECT, {18'h0, 6'($urandom_range(0, 4)), 1'b0, 7'($urandom_range(0, 6))});
      else if (sel < 47) do_op(OP_STAT_WR, $urandom());
      else if (sel < 60) do_op(OP_READ, 0);
      else if (sel < 70) do_op(OP_STAT_RD, 0);
      else               do_op(OP_IDLE, 0);
    end

    repeat (100) do_op(OP_IDLE, 0);
    do_op(OP_STAT_RD, 0);
    do_op(OP_READ, 0);
    repeat (3) do_op(OP_IDLE, 0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'h0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
